// File: rtl/soda_arbiter.sv
// Two-panel round-robin arbiter for a shared soda vending core, with idle timeout abort.
// Optional build macro SODA_ARB_FIXED_PRIO_EN: panel 0 always wins simultaneous requests.
module soda_arbiter #(
    parameter int TIMEOUT_CYC = 1000,
    parameter int TW          = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic [1:0] next_in,
    input  logic [1:0] coin_in0,
    input  logic [1:0] coin_in1,
    input  logic       core_soda,
    input  logic [1:0] core_coin_out,
    output logic       core_next,
    output logic [1:0] core_coin_in,
    output logic [1:0] grant,
    output logic [1:0] soda,
    output logic [1:0] coin_out0,
    output logic [1:0] coin_out1,
    output logic       abort,
    output logic [1:0] arb_state
);
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_GRANT   = 2'd1,
        S_VEND    = 2'd2,
        S_RELEASE = 2'd3
    } state_t;

    localparam logic [TW-1:0] TIMER_LIM = TW'(TIMEOUT_CYC - 1);

    state_t        r_state, w_state_nxt;
    logic [1:0]    r_grant, w_grant_nxt;
    logic          r_owner, w_owner_nxt;
    logic          r_last, w_last_nxt;
    logic [TW-1:0] r_timer, w_timer_nxt;
    logic [1:0]    r_next_s1, r_next_s2;
    logic [1:0]    w_next_edge;
    logic          w_owner_edge;
    logic          w_pick;
    logic          w_timeout;

    assign w_next_edge  = r_next_s1 & ~r_next_s2;
    assign w_owner_edge = r_owner ? w_next_edge[1] : w_next_edge[0];

    always_comb begin
        case (req)
            2'b01:   w_pick = 1'b0;
            2'b10:   w_pick = 1'b1;
`ifdef SODA_ARB_FIXED_PRIO_EN
            default: w_pick = 1'b0;
`else
            default: w_pick = ~r_last;
`endif
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_grant   <= 2'b00;
            r_owner   <= 1'b0;
            r_last    <= 1'b1;
            r_timer   <= '0;
            r_next_s1 <= 2'b00;
            r_next_s2 <= 2'b00;
        end else begin
            r_state   <= w_state_nxt;
            r_grant   <= w_grant_nxt;
            r_owner   <= w_owner_nxt;
            r_last    <= w_last_nxt;
            r_timer   <= w_timer_nxt;
            r_next_s1 <= next_in;
            r_next_s2 <= r_next_s1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_owner_nxt = r_owner;
        w_last_nxt  = r_last;
        w_timer_nxt = '0;
        w_timeout   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (req != 2'b00) begin
                    w_state_nxt = S_GRANT;
                    w_owner_nxt = w_pick;
                    w_grant_nxt = w_pick ? 2'b10 : 2'b01;
                end
            end
            S_GRANT: begin
                w_timer_nxt = w_owner_edge ? '0 : r_timer + TW'(1);
                // A vend in progress wins over a timeout landing in the same cycle
                if (core_soda) begin
                    w_state_nxt = S_VEND;
                end else if (r_timer == TIMER_LIM) begin
                    w_state_nxt = S_RELEASE;
                    w_grant_nxt = 2'b00;
                    w_timeout   = 1'b1;
                end
            end
            S_VEND: begin
                if (!core_soda) begin
                    w_state_nxt = S_RELEASE;
                    w_grant_nxt = 2'b00;
                end
            end
            S_RELEASE: begin
                w_last_nxt  = r_owner;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_grant_nxt = 2'b00;
            end
        endcase
    end

    // Grant is one-hot or zero, so masking by it steers traffic to the owner only
    assign core_next    = |(r_grant & next_in);
    assign core_coin_in = ({2{r_grant[0]}} & coin_in0) | ({2{r_grant[1]}} & coin_in1);
    assign soda         = r_grant & {2{core_soda}};
    assign coin_out0    = {2{r_grant[0]}} & core_coin_out;
    assign coin_out1    = {2{r_grant[1]}} & core_coin_out;
    assign grant        = r_grant;
    assign abort        = w_timeout;
    assign arb_state    = r_state;
endmodule

// File: tb/tb_soda_arbiter.sv
// Self-checking bench for soda_arbiter: transaction-level model compared every cycle,
// plus directed literal checks for arbitration, steering, timeout and reset.
module tb_soda_arbiter;
    localparam int TO = 8;
`ifdef SODA_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
    localparam logic [1:0] EXP_SECOND = 2'b01;
`else
    localparam bit FIXED = 1'b0;
    localparam logic [1:0] EXP_SECOND = 2'b10;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [1:0] req = 2'b00;
    logic [1:0] next_in = 2'b00;
    logic [1:0] coin_in0 = 2'b00;
    logic [1:0] coin_in1 = 2'b00;
    logic       core_soda = 1'b0;
    logic [1:0] core_coin_out = 2'b00;
    logic       core_next;
    logic [1:0] core_coin_in, grant, soda, coin_out0, coin_out1, arb_state;
    logic       abort;

    int checks = 0;
    int failures = 0;

    soda_arbiter #(.TIMEOUT_CYC(TO), .TW(10)) dut (
        .clk(clk), .reset(reset), .req(req), .next_in(next_in),
        .coin_in0(coin_in0), .coin_in1(coin_in1), .core_soda(core_soda),
        .core_coin_out(core_coin_out), .core_next(core_next),
        .core_coin_in(core_coin_in), .grant(grant), .soda(soda),
        .coin_out0(coin_out0), .coin_out1(coin_out1), .abort(abort),
        .arb_state(arb_state)
    );

    always #5 clk = ~clk;

    // Transaction model: who owns the core, whether it is vending or releasing,
    // and how many idle cycles have passed since the owner's last next press.
    int         m_owner;
    bit         m_rel, m_vend;
    int         m_timer, m_last;
    logic [1:0] m_h1, m_h2;

    function automatic int pick(logic [1:0] r, int last);
        if (r == 2'b01) return 0;
        if (r == 2'b10) return 1;
        if (FIXED) return 0;
        return 1 - last;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_owner <= -1; m_rel <= 1'b0; m_vend <= 1'b0;
            m_timer <= 0;  m_last <= 1;   m_h1 <= 2'b00; m_h2 <= 2'b00;
        end else begin
            m_h1 <= next_in;
            m_h2 <= m_h1;
            if (m_rel) begin
                m_last <= m_owner; m_owner <= -1; m_rel <= 1'b0;
                m_vend <= 1'b0;    m_timer <= 0;
            end else if (m_owner < 0) begin
                if (req != 2'b00) begin
                    m_owner <= pick(req, m_last);
                    m_timer <= 0;
                end
            end else if (!m_vend) begin
                m_timer <= (m_h1[m_owner] && !m_h2[m_owner]) ? 0 : m_timer + 1;
                if (core_soda) m_vend <= 1'b1;
                else if (m_timer == TO - 1) m_rel <= 1'b1;
            end else if (!core_soda) begin
                m_rel <= 1'b1;
            end
        end
    end

    function automatic logic [1:0] e_grant();
        if (m_owner >= 0 && !m_rel) return 2'(1 << m_owner);
        return 2'b00;
    endfunction

    function automatic logic [1:0] e_state();
        if (m_rel) return 2'd3;
        if (m_owner < 0) return 2'd0;
        return m_vend ? 2'd2 : 2'd1;
    endfunction

    task automatic chk(input string name, input logic [1:0] act, input logic [1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%b required=%b at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        logic [1:0] g;
        logic       own;
        g   = e_grant();
        own = (m_owner == 1);
        chk("m_grant", grant, g);
        chk("m_state", arb_state, e_state());
        chk("m_abort", {1'b0, abort},
            {1'b0, (e_state() == 2'd1) && !core_soda && (m_timer == TO - 1)});
        chk("m_core_next", {1'b0, core_next}, {1'b0, (g != 2'b00) && next_in[own]});
        chk("m_core_coin_in", core_coin_in,
            g == 2'b01 ? coin_in0 : (g == 2'b10 ? coin_in1 : 2'b00));
        chk("m_soda", soda, core_soda ? g : 2'b00);
        chk("m_coin_out0", coin_out0, g == 2'b01 ? core_coin_out : 2'b00);
        chk("m_coin_out1", coin_out1, g == 2'b10 ? core_coin_out : 2'b00);
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_vend();
        core_soda = 1'b1;
        cyc(1);
        core_soda = 1'b0;
        cyc(2);
    endtask

    initial begin
        cyc(2);
        chk("reset_grant", grant, 2'b00);
        chk("reset_state", arb_state, 2'd0);
        chk("reset_abort", {1'b0, abort}, 2'b00);
        reset = 1'b1;
        cyc(1);

        // Simultaneous requests twice: panel 0 first, then rotation
        req = 2'b11;
        cyc(1);
        chk("rr_first", grant, 2'b01);
        req = 2'b00;
        core_soda = 1'b1;
        cyc(1);
        core_soda = 1'b0;
        cyc(1);
        chk("release_state", arb_state, 2'd3);
        chk("release_grant", grant, 2'b00);
        cyc(1);
        req = 2'b11;
        cyc(1);
        chk("rr_second", grant, EXP_SECOND);
        req = 2'b00;
        do_vend();

        // Panel 1 vend with soda held three cycles
        req = 2'b10;
        cyc(1);
        chk("p1_grant", grant, 2'b10);
        req = 2'b00; coin_in1 = 2'b01; next_in = 2'b10; core_coin_out = 2'b11;
        #1;
        chk("p1_coin_in", core_coin_in, 2'b01);
        chk("p1_next", {1'b0, core_next}, 2'b01);
        cyc(2);
        core_soda = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("p1_soda", soda, 2'b10);
            chk("p1_coin_out0", coin_out0, 2'b00);
            chk("p1_coin_out1", coin_out1, 2'b11);
            if (i < 2) cyc(1);
        end
        core_soda = 1'b0;
        cyc(1);
        chk("p1_rel_state", arb_state, 2'd3);
        chk("p1_rel_grant", grant, 2'b00);
        chk("p1_rel_coin_out1", coin_out1, 2'b00);
        cyc(1);
        next_in = 2'b00; coin_in1 = 2'b00; core_coin_out = 2'b00;

        // Timeout with no next presses, then a press that restarts the count
        req = 2'b01;
        cyc(1);
        chk("to_grant", grant, 2'b01);
        req = 2'b00;
        cyc(7);
        chk("to_abort", {1'b0, abort}, 2'b01);
        chk("to_abort_state", arb_state, 2'd1);
        cyc(1);
        chk("to_after_grant", grant, 2'b00);
        chk("to_after_state", arb_state, 2'd3);
        chk("to_after_abort", {1'b0, abort}, 2'b00);
        cyc(1);
        req = 2'b01;
        cyc(1);
        req = 2'b00;
        cyc(4);
        next_in = 2'b01;
        cyc(3);
        chk("restart_no_abort", {1'b0, abort}, 2'b00);
        cyc(6);
        chk("restart_abort", {1'b0, abort}, 2'b01);
        cyc(1);
        next_in = 2'b00;
        cyc(1);

        // Non-owner panel activity must not reach the core
        req = 2'b01;
        cyc(1);
        req = 2'b00; coin_in0 = 2'b10; coin_in1 = 2'b11; core_coin_out = 2'b10;
        for (int i = 0; i < 4; i++) begin
            next_in = {i[0], (i >= 2) ? 1'b1 : 1'b0};
            #1;
            chk("iso_next", {1'b0, core_next}, {1'b0, (i >= 2) ? 1'b1 : 1'b0});
            chk("iso_coin_in", core_coin_in, 2'b10);
            chk("iso_coin_out0", coin_out0, 2'b10);
            chk("iso_coin_out1", coin_out1, 2'b00);
            cyc(1);
        end
        next_in = 2'b00; coin_in0 = 2'b00; coin_in1 = 2'b00; core_coin_out = 2'b00;
        do_vend();

        // Soda arriving on the timeout cycle wins
        req = 2'b10;
        cyc(1);
        req = 2'b00;
        cyc(7);
        chk("tie_pre_abort", {1'b0, abort}, 2'b01);
        core_soda = 1'b1;
        #1;
        chk("tie_no_abort", {1'b0, abort}, 2'b00);
        cyc(1);
        chk("tie_vend_state", arb_state, 2'd2);
        core_soda = 1'b0;
        cyc(2);

        // Asynchronous reset while panel 1 owns the core
        req = 2'b10;
        cyc(1);
        chk("ar_owner1", grant, 2'b10);
        req = 2'b00;
        cyc(1);
        reset = 1'b0;
        #1;
        chk("ar_grant", grant, 2'b00);
        chk("ar_state", arb_state, 2'd0);
        cyc(1);
        reset = 1'b1;
        req = 2'b11;
        cyc(1);
        chk("ar_rr_restart", grant, 2'b01);
        req = 2'b00;
        do_vend();
        cyc(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
